// File: rtl/dense_activate_back_reg.sv
// ----------------------------------------------------------------------------
// dense_activate_back_reg
//
// Elastic backward-path register between the activation-derivative stage and
// the dense weight-update stage. A 2-entry skid buffer carries the gradient
// bundle with valid/ready on both sides, so downstream stalls never drop data.
// It also counts beat position within a layer burst and flags the last beat.
//
// Ports
//   clk, rst_n                  clock, async active-low reset
//   flush                       sync clear of buffer and beat counter
//   in_valid / in_ready         upstream handshake
//   act_type .. backprop_controll  incoming bundle fields
//   burst_len                   beats per burst (0 treated as 1)
//   out_valid / out_ready       downstream handshake
//   *_out                       head (oldest) entry fields
//   out_last                    head is the last beat of its burst
//   occupancy                   entries held (0..2)
// ----------------------------------------------------------------------------
module dense_activate_back_reg #(
    parameter int unsigned size                   = 3,
    parameter int unsigned data_size              = 16,
    parameter int unsigned cost_type_size         = 8,
    parameter int unsigned dense_type_size        = 4,
    parameter int unsigned act_type_size          = 4,
    parameter int unsigned backprop_controll_size = 66
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              flush,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [act_type_size-1:0]          act_type,
    input  logic [dense_type_size-1:0]        dense_type,
    input  logic [cost_type_size-1:0]         cost_type,
    input  logic [data_size*size-1:0]         grad,
    input  logic [data_size*size-1:0]         x,
    input  logic [data_size*size-1:0]         w,
    input  logic [backprop_controll_size-1:0] backprop_controll,
    input  logic [7:0]                        burst_len,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [act_type_size-1:0]          act_type_out,
    output logic [dense_type_size-1:0]        dense_type_out,
    output logic [cost_type_size-1:0]         cost_type_out,
    output logic [data_size*size-1:0]         grad_out,
    output logic [data_size*size-1:0]         x_out,
    output logic [data_size*size-1:0]         w_out,
    output logic [backprop_controll_size-1:0] backprop_controll_out,
    output logic                              out_last,
    output logic [1:0]                        occupancy
);

    localparam int unsigned vec_w   = data_size * size;
    localparam int unsigned entry_w = act_type_size + dense_type_size + cost_type_size
                                      + 3 * vec_w + backprop_controll_size;

    logic [entry_w-1:0] in_entry;
    logic [entry_w-1:0] head_q, head_d;
    logic [entry_w-1:0] tail_q, tail_d;
    logic [1:0]         occ_q, occ_d;
    logic [7:0]         beat_idx_q, beat_idx_d;
    logic [7:0]         last_idx;
    logic               push, pop;

    assign in_entry = {act_type, dense_type, cost_type, grad, x, w, backprop_controll};

    // Head register drives the outputs directly: no path from out_ready.
    assign {act_type_out, dense_type_out, cost_type_out, grad_out, x_out, w_out,
            backprop_controll_out} = head_q;

    assign occupancy = occ_q;
    assign in_ready  = (occ_q != 2'd2);
    assign out_valid = (occ_q != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // burst_len of 0 behaves as a single-beat burst.
    assign last_idx = (burst_len == 8'd0) ? 8'd0 : burst_len - 8'd1;
    assign out_last = out_valid & (beat_idx_q == last_idx);

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        occ_d      = occ_q;
        beat_idx_d = beat_idx_q;

        if (flush) begin
            occ_d      = 2'd0;
            beat_idx_d = 8'd0;
        end else begin
            unique case (occ_q)
                2'd0: begin
                    if (push) begin
                        head_d = in_entry;
                        occ_d  = 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head_d = in_entry;
                    end else if (push) begin
                        tail_d = in_entry;
                        occ_d  = 2'd2;
                    end else if (pop) begin
                        occ_d = 2'd0;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        head_d = tail_q;
                        occ_d  = 2'd1;
                    end
                end
                default: begin
                    occ_d = 2'd0;
                end
            endcase

            if (pop) begin
                beat_idx_d = out_last ? 8'd0 : beat_idx_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            occ_q      <= 2'd0;
            beat_idx_q <= 8'd0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            occ_q      <= occ_d;
            beat_idx_q <= beat_idx_d;
        end
    end

endmodule

// File: tb/tb_dense_activate_back_reg.sv
// ----------------------------------------------------------------------------
// tb_dense_activate_back_reg
//
// Self-checking bench: directed scenarios followed by a randomized phase,
// compared against a queue-based reference model of the skid buffer.
// ----------------------------------------------------------------------------
module tb_dense_activate_back_reg;

    localparam int EW = 4 + 4 + 8 + 3 * 48 + 66;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  act_type;
    logic [3:0]  dense_type;
    logic [7:0]  cost_type;
    logic [47:0] grad;
    logic [47:0] x;
    logic [47:0] w;
    logic [65:0] ctrl;
    logic [7:0]  burst_len;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  act_type_out;
    logic [3:0]  dense_type_out;
    logic [7:0]  cost_type_out;
    logic [47:0] grad_out;
    logic [47:0] x_out;
    logic [47:0] w_out;
    logic [65:0] ctrl_out;
    logic        out_last;
    logic [1:0]  occupancy;

    logic [EW-1:0] cur;
    logic [EW-1:0] out_bundle;

    assign {act_type, dense_type, cost_type, grad, x, w, ctrl} = cur;
    assign out_bundle = {act_type_out, dense_type_out, cost_type_out, grad_out, x_out, w_out,
                         ctrl_out};

    dense_activate_back_reg dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .flush                 (flush),
        .in_valid              (in_valid),
        .in_ready              (in_ready),
        .act_type              (act_type),
        .dense_type            (dense_type),
        .cost_type             (cost_type),
        .grad                  (grad),
        .x                     (x),
        .w                     (w),
        .backprop_controll     (ctrl),
        .burst_len             (burst_len),
        .out_valid             (out_valid),
        .out_ready             (out_ready),
        .act_type_out          (act_type_out),
        .dense_type_out        (dense_type_out),
        .cost_type_out         (cost_type_out),
        .grad_out              (grad_out),
        .x_out                 (x_out),
        .w_out                 (w_out),
        .backprop_controll_out (ctrl_out),
        .out_last              (out_last),
        .occupancy             (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: FIFO contents plus the beat position in the burst.
    logic [EW-1:0] q[$];
    int            mbeat;
    int            n_vec;
    int            n_err;
    logic          last_push;

    function automatic int burst_l();
        return (burst_len == 8'd0) ? 1 : int'(burst_len);
    endfunction

    function automatic logic [EW-1:0] rand_bundle();
        logic [255:0] t;
        for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom();
        return t[EW-1:0];
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check("occupancy", occupancy, q.size());
        check("in_ready", in_ready, q.size() < 2);
        check("out_valid", out_valid, q.size() > 0);
        check("out_last", out_last, (q.size() > 0) && (mbeat == burst_l() - 1));
        check("beat_idx", dut.beat_idx_q, mbeat);
        if (q.size() > 0) check("head", out_bundle, q[0]);
    endtask

    // Check state, then advance one clock and update the model.
    task automatic step();
        logic push, pop, last;
        check_outputs();
        push = in_valid && (q.size() < 2);
        pop  = (q.size() > 0) && out_ready;
        last = (q.size() > 0) && (mbeat == burst_l() - 1);
        @(posedge clk);
        #1;
        if (flush) begin
            q.delete();
            mbeat = 0;
        end else begin
            if (pop) begin
                void'(q.pop_front());
                mbeat = last ? 0 : mbeat + 1;
            end
            if (push) q.push_back(cur);
        end
        last_push = push && !flush;
    endtask

    // Drive one bundle and hold it until accepted, with a cycle bound.
    task automatic send(input logic [EW-1:0] b);
        int guard;
        cur      = b;
        in_valid = 1'b1;
        guard    = 0;
        do begin
            step();
            guard++;
        end while (!last_push && guard < 20);
        if (!last_push) check("send_timeout", 1'b0, 1'b1);
        in_valid = 1'b0;
    endtask

    // Stream filler beats until the buffer is empty and the burst has wrapped.
    task automatic realign();
        int guard;
        int need;
        out_ready = 1'b1;
        guard     = 0;
        while (!(q.size() == 0 && mbeat == 0) && guard < 40) begin
            need     = (burst_l() - mbeat) % burst_l();
            in_valid = (need > q.size());
            cur      = rand_bundle();
            step();
            guard++;
        end
        in_valid = 1'b0;
        if (guard >= 40) check("realign_timeout", 1'b0, 1'b1);
    endtask

    initial begin
        logic [EW-1:0] b;
        n_vec     = 0;
        n_err     = 0;
        mbeat     = 0;
        last_push = 1'b0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        burst_len = 8'd1;
        cur       = '0;

        // Reset values
        #12;
        check_outputs();
        check("reset_data", out_bundle, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single push, burst_len = 1
        b = '0;
        b[EW-1 -: 4] = 4'd2;
        b[245 - 66 - 144 + 144 - 1 -: 0 + 1] = b[245 - 66 - 144 + 144 - 1 -: 1];
        cur = b;
        cur[66 + 96 +: 48] = 48'h0003_0002_0001;
        b   = cur;
        out_ready = 1'b1;
        send(b);
        check("single_grad", grad_out, 48'h0003_0002_0001);
        check("single_act", act_type_out, 4'd2);
        check("single_last", out_last, 1'b1);
        step();
        check("single_drained", occupancy, 0);

        // Streaming 10 beats, burst_len = 4
        burst_len = 8'd4;
        in_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cur = rand_bundle();
            step();
            check("stream_accept", last_push, 1'b1);
        end
        in_valid = 1'b0;
        step();
        check("stream_beat_end", dut.beat_idx_q, 8'd2);
        realign();

        // Backpressure: A, B stored, C held, then released in order
        out_ready = 1'b0;
        send(rand_bundle());
        send(rand_bundle());
        cur      = rand_bundle();
        in_valid = 1'b1;
        step();
        check("bp_c_held", last_push, 1'b0);
        check("bp_full_ready", in_ready, 1'b0);
        step();
        out_ready = 1'b1;
        send(cur);
        for (int i = 0; i < 4; i++) step();
        check("bp_drained", occupancy, 0);
        realign();

        // Simultaneous push + pop at occupancy 1
        out_ready = 1'b0;
        send(rand_bundle());
        out_ready = 1'b1;
        b = rand_bundle();
        send(b);
        check("pp_occ", occupancy, 1);
        check("pp_head", out_bundle, b);
        step();
        realign();

        // Flush at occupancy 2 with a push in the same cycle
        burst_len = 8'd2;
        out_ready = 1'b0;
        send(rand_bundle());
        send(rand_bundle());
        cur      = rand_bundle();
        in_valid = 1'b1;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_occ", occupancy, 0);
        check("flush_valid", out_valid, 1'b0);
        check("flush_beat", dut.beat_idx_q, 0);
        step();
        out_ready = 1'b1;
        send(rand_bundle());
        send(rand_bundle());
        step();
        realign();

        // Async reset mid-cycle at occupancy 2
        out_ready = 1'b0;
        send(rand_bundle());
        send(rand_bundle());
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        mbeat = 0;
        check_outputs();
        check("areset_data", out_bundle, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        b = rand_bundle();
        send(b);
        check("post_reset_head", out_bundle, b);
        check("post_reset_last", out_last, 1'b0);
        realign();

        // Randomized phase
        for (int i = 0; i < 400; i++) begin
            if (!in_valid || last_push) begin
                in_valid = ($urandom_range(0, 3) != 0);
                cur      = rand_bundle();
            end
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 40) == 0);
            if (mbeat == 0 && q.size() == 0 && $urandom_range(0, 7) == 0)
                burst_len = 8'($urandom_range(0, 5));
            step();
        end
        flush    = 1'b0;
        in_valid = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
